// File: rtl/imem_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// imem_fetch_sequencer
//
// Fetches variable-length instructions (1, 2, 9 or 10 bytes) one byte per
// cycle from a byte-wide, combinational-read instruction memory and presents
// each assembled instruction to decode over a valid/ready handshake. After
// acceptance the PC advances to valP; a redirect aborts the current fetch and
// restarts at redirect_pc.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start, start_pc         begin fetching (sampled in IDLE and ERROR)
//   redirect, redirect_pc   abort and refetch (FETCH0 / FETCHN / HOLD)
//   mem_addr, mem_rdata     registered byte address, same-cycle read data
//   instr_valid/ready       instruction handshake to decode
//   icode_ifun              byte 0 of the instruction
//   instr_tail              bytes pc+1..pc+9 (unfetched bytes are zero)
//   instr_len, valP         instruction length and pc + length
//   instr_invalid           icode above 4'hB
//   imem_error              sticky out-of-range fetch
//   busy                    fetching or holding an instruction
// ---------------------------------------------------------------------------
module imem_fetch_sequencer #(
    parameter int MEM_DEPTH = 2048,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        icode_ifun,
    output logic [71:0]       instr_tail,
    output logic [3:0]        instr_len,
    output logic [ADDR_W-1:0] valP,
    output logic              instr_invalid,
    output logic              imem_error,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH0 = 3'd1,
        FETCHN = 3'd2,
        HOLD   = 3'd3,
        ERROR  = 3'd4
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [3:0]        cnt_reg;
    // Carry-out of the address/valP adders: a wrapped address is treated as
    // out of range even though its low bits may look valid.
    logic              addr_wrap_reg;
    logic              valp_wrap_reg;

    // Length decode of the byte currently on mem_rdata (used in FETCH0).
    logic [3:0] fetch_len;
    logic       fetch_bad;

    always_comb begin
        fetch_len = 4'd1;
        fetch_bad = 1'b0;
        case (mem_rdata[7:4])
            4'h0, 4'h1, 4'h9:       fetch_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: fetch_len = 4'd2;
            4'h7, 4'h8:             fetch_len = 4'd9;
            4'h3, 4'h4, 4'h5:       fetch_len = 4'd10;
            default: begin
                fetch_len = 4'd1;
                fetch_bad = 1'b1;
            end
        endcase
    end

    logic [ADDR_W:0] fetch_valp;
    logic [ADDR_W:0] first_tail_addr;
    logic [ADDR_W:0] next_tail_addr;
    logic            addr_fault;
    logic            last_tail;

    assign fetch_valp      = {1'b0, pc_reg} + {{(ADDR_W-3){1'b0}}, fetch_len};
    assign first_tail_addr = {1'b0, pc_reg} + (ADDR_W+1)'(1);
    assign next_tail_addr  = {1'b0, pc_reg} + {{(ADDR_W-3){1'b0}}, cnt_reg} + (ADDR_W+1)'(1);
    assign addr_fault      = addr_wrap_reg || (mem_addr > LAST_ADDR);
    assign last_tail       = (cnt_reg == instr_len - 4'd1);

    // One write enable per tail byte: byte cnt-1 is written in FETCHN.
    logic [8:0] tail_we;
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tail_we
            assign tail_we[gi] = (cnt_reg == 4'(gi + 1));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pc_reg        <= '0;
            cnt_reg       <= '0;
            addr_wrap_reg <= 1'b0;
            valp_wrap_reg <= 1'b0;
            mem_addr      <= '0;
            instr_valid   <= 1'b0;
            icode_ifun    <= '0;
            instr_tail    <= '0;
            instr_len     <= '0;
            valP          <= '0;
            instr_invalid <= 1'b0;
            imem_error    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, ERROR: begin
                    if (start) begin
                        pc_reg        <= start_pc;
                        mem_addr      <= start_pc;
                        addr_wrap_reg <= 1'b0;
                        instr_tail    <= '0;
                        cnt_reg       <= '0;
                        imem_error    <= 1'b0;
                        busy          <= 1'b1;
                        state_reg     <= FETCH0;
                    end
                end

                FETCH0, FETCHN, HOLD: begin
                    if (redirect) begin
                        // Redirect wins over a same-cycle handshake.
                        pc_reg        <= redirect_pc;
                        mem_addr      <= redirect_pc;
                        addr_wrap_reg <= 1'b0;
                        instr_tail    <= '0;
                        cnt_reg       <= '0;
                        instr_valid   <= 1'b0;
                        state_reg     <= FETCH0;
                    end else if (state_reg != HOLD && addr_fault) begin
                        imem_error  <= 1'b1;
                        instr_valid <= 1'b0;
                        busy        <= 1'b0;
                        state_reg   <= ERROR;
                    end else if (state_reg == FETCH0) begin
                        icode_ifun    <= mem_rdata;
                        instr_len     <= fetch_len;
                        instr_invalid <= fetch_bad;
                        valP          <= fetch_valp[ADDR_W-1:0];
                        valp_wrap_reg <= fetch_valp[ADDR_W];
                        if (fetch_len == 4'd1) begin
                            instr_valid <= 1'b1;
                            state_reg   <= HOLD;
                        end else begin
                            cnt_reg       <= 4'd1;
                            mem_addr      <= first_tail_addr[ADDR_W-1:0];
                            addr_wrap_reg <= first_tail_addr[ADDR_W];
                            state_reg     <= FETCHN;
                        end
                    end else if (state_reg == FETCHN) begin
                        for (int i = 0; i < 9; i++) begin
                            if (tail_we[i]) begin
                                instr_tail[8*i +: 8] <= mem_rdata;
                            end
                        end
                        if (last_tail) begin
                            instr_valid <= 1'b1;
                            state_reg   <= HOLD;
                        end else begin
                            cnt_reg       <= cnt_reg + 4'd1;
                            mem_addr      <= next_tail_addr[ADDR_W-1:0];
                            addr_wrap_reg <= next_tail_addr[ADDR_W];
                        end
                    end else if (instr_ready) begin
                        // HOLD with handshake: halt or invalid stops the
                        // sequencer, anything else falls through to valP.
                        instr_valid <= 1'b0;
                        if (icode_ifun[7:4] == 4'h0 || instr_invalid) begin
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            pc_reg        <= valP;
                            mem_addr      <= valP;
                            addr_wrap_reg <= valp_wrap_reg;
                            instr_tail    <= '0;
                            cnt_reg       <= '0;
                            state_reg     <= FETCH0;
                        end
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_sequencer
//
// Bench for imem_fetch_sequencer. A byte array models the instruction memory
// with combinational read. Expected instructions are queued when a test is
// set up and popped by a monitor whenever decode accepts an instruction.
// ---------------------------------------------------------------------------
module tb_imem_fetch_sequencer;

    localparam int ADDR_W = 64;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        icode_ifun;
    logic [71:0]       instr_tail;
    logic [3:0]        instr_len;
    logic [ADDR_W-1:0] valP;
    logic              instr_invalid;
    logic              imem_error;
    logic              busy;

    imem_fetch_sequencer #(
        .MEM_DEPTH (2048),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_pc      (start_pc),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .icode_ifun    (icode_ifun),
        .instr_tail    (instr_tail),
        .instr_len     (instr_len),
        .valP          (valP),
        .instr_invalid (instr_invalid),
        .imem_error    (imem_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:2047];
    assign mem_rdata = (mem_addr < 64'd2048) ? mem[mem_addr[10:0]] : 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0]        ii;
        logic [71:0]       tail;
        logic [3:0]        len;
        logic [ADDR_W-1:0] valp;
        logic              inv;
    } exp_t;

    exp_t sb[$];
    exp_t sb_e;

    task automatic push_exp(input logic [7:0] ii, input logic [71:0] tail,
                            input logic [3:0] len, input logic [ADDR_W-1:0] valp,
                            input logic inv);
        exp_t e;
        e.ii   = ii;
        e.tail = tail;
        e.len  = len;
        e.valp = valp;
        e.inv  = inv;
        sb.push_back(e);
    endtask

    // Monitor: mid-cycle, a valid && ready without redirect is a handshake
    // that the next rising edge completes.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_instr", 128'(icode_ifun), 128'h1ff);
            end else begin
                sb_e = sb.pop_front();
                check("sb_icode_ifun", 128'(icode_ifun), 128'(sb_e.ii));
                check("sb_tail", 128'(instr_tail), 128'(sb_e.tail));
                check("sb_len", 128'(instr_len), 128'(sb_e.len));
                check("sb_valP", 128'(valP), 128'(sb_e.valp));
                check("sb_invalid", 128'(instr_invalid), 128'(sb_e.inv));
                $display("instr accepted: icode_ifun=%02h len=%0d valP=%0d tail=%018h",
                         icode_ifun, instr_len, valP, instr_tail);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    endtask

    // Pulse start for one edge and return the number of edges (counting the
    // one that samples start) until instr_valid is seen.
    task automatic start_and_wait(input logic [ADDR_W-1:0] pc, output int n);
        start_pc = pc;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!instr_valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("idle_reached", 128'(busy), 128'(0));
        check("sb_drained", 128'(sb.size()), 128'(0));
    endtask

    int n;

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        start_pc    = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        clear_mem();

        // ---- power-up reset values ----
        #1;
        check("rst_valid", 128'(instr_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_error", 128'(imem_error), 128'(0));
        check("rst_len", 128'(instr_len), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---- reset asserted mid-FETCHN ----
        mem[1] = 8'h30; mem[2] = 8'hF8; mem[3] = 8'h0A;
        start_pc = 64'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (mem_addr != 64'd4 && n < 20) begin
            tick();
            n++;
        end
        check("midrst_reach_byte3", 128'(mem_addr), 128'(4));
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_mem_addr", 128'(mem_addr), 128'(0));
        check("midrst_icode", 128'(icode_ifun), 128'(0));
        check("midrst_tail", 128'(instr_tail), 128'(0));
        check("midrst_valP", 128'(valP), 128'(0));
        tick();
        tick();
        check("midrst_start_ignored_busy", 128'(busy), 128'(0));
        check("midrst_start_ignored_addr", 128'(mem_addr), 128'(0));
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        $display("test reset-mid-fetch done");

        // ---- nop then halt at 0 ----
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h00;
        push_exp(8'h10, 72'h0, 4'd1, 64'd1, 1'b0);
        push_exp(8'h00, 72'h0, 4'd1, 64'd2, 1'b0);
        instr_ready = 1'b1;
        start_and_wait(64'd0, n);
        check("nop_latency", 128'(n), 128'(2));
        wait_idle();
        tick(); tick(); tick();
        check("halt_no_more_reads", 128'(mem_addr), 128'(1));
        check("halt_valid_low", 128'(instr_valid), 128'(0));
        $display("test nop-halt done");

        // ---- irmovq at 1 with backpressure ----
        clear_mem();
        mem[1] = 8'h30; mem[2] = 8'hF8; mem[3] = 8'h0A; mem[11] = 8'h00;
        push_exp(8'h30, 72'h0AF8, 4'd10, 64'd11, 1'b0);
        push_exp(8'h00, 72'h0, 4'd1, 64'd12, 1'b0);
        instr_ready = 1'b0;
        start_and_wait(64'd1, n);
        check("irmovq_latency", 128'(n), 128'(11));
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 128'(instr_valid), 128'(1));
            check("bp_icode", 128'(icode_ifun), 128'h30);
            check("bp_tail", 128'(instr_tail), 128'h0AF8);
            check("bp_valP", 128'(valP), 128'(11));
            tick();
        end
        instr_ready = 1'b1;
        tick();
        check("bp_next_fetch_addr", 128'(mem_addr), 128'(11));
        check("bp_valid_drop", 128'(instr_valid), 128'(0));
        wait_idle();
        $display("test backpressure done");

        // ---- redirect during irmovq byte 4 ----
        clear_mem();
        mem[1] = 8'h30; mem[2] = 8'hF8; mem[3] = 8'h0A;
        mem[112] = 8'h30; mem[113] = 8'hF8; mem[114] = 8'h08; mem[122] = 8'h00;
        push_exp(8'h30, 72'h08F8, 4'd10, 64'd122, 1'b0);
        push_exp(8'h00, 72'h0, 4'd1, 64'd123, 1'b0);
        start_pc = 64'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (mem_addr != 64'd5 && n < 20) begin
            tick();
            n++;
        end
        check("redir_reach_byte4", 128'(mem_addr), 128'(5));
        redirect    = 1'b1;
        redirect_pc = 64'd112;
        tick();
        redirect = 1'b0;
        check("redir_mem_addr", 128'(mem_addr), 128'(112));
        check("redir_valid", 128'(instr_valid), 128'(0));
        check("redir_busy", 128'(busy), 128'(1));
        wait_idle();
        $display("test redirect done");

        // ---- OPq / jXX / invalid chain from 0 ----
        clear_mem();
        mem[0] = 8'h60; mem[1] = 8'h23;
        mem[2] = 8'h70; mem[3] = 8'h11; mem[4] = 8'h22; mem[5] = 8'h33; mem[6] = 8'h44;
        mem[7] = 8'h55; mem[8] = 8'h66; mem[9] = 8'h77; mem[10] = 8'h88;
        mem[11] = 8'hC0;
        push_exp(8'h60, 72'h23, 4'd2, 64'd2, 1'b0);
        push_exp(8'h70, 72'h00_8877665544332211, 4'd9, 64'd11, 1'b0);
        push_exp(8'hC0, 72'h0, 4'd1, 64'd12, 1'b1);
        start_and_wait(64'd0, n);
        check("opq_latency", 128'(n), 128'(3));
        wait_idle();
        $display("test length-chain done");

        // ---- out-of-range fetch ----
        clear_mem();
        mem[2040] = 8'h30;
        start_pc = 64'd2040;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!imem_error && n < 40) begin
            tick();
            n++;
        end
        check("err_latency", 128'(n), 128'(10));
        check("err_flag", 128'(imem_error), 128'(1));
        check("err_busy", 128'(busy), 128'(0));
        check("err_valid", 128'(instr_valid), 128'(0));
        check("err_addr", 128'(mem_addr), 128'(2048));
        tick(); tick(); tick();
        check("err_sticky", 128'(imem_error), 128'(1));
        mem[0] = 8'h00;
        push_exp(8'h00, 72'h0, 4'd1, 64'd1, 1'b0);
        start_pc = 64'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("err_cleared", 128'(imem_error), 128'(0));
        check("err_restart_busy", 128'(busy), 128'(1));
        wait_idle();
        $display("test error done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
